mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port pipelined memory between instruction fetch (IF) and the MEM-stage
//   data port (DM), replacing the separate instruction and data memories.
//   Arbitrates per cycle: DM has priority, with a starvation guard for IF.
//   Tracks outstanding reads in an in-order tag FIFO and routes returned data to the owner.
//   Drives per-port stall lines into the PC / pipeline-register stall logic.
// PARAMETERS
//   ADDR_W      12  memory byte-address width passed to the memory (4 KB)
//   MAX_OUTST    4  maximum outstanding reads, which is the tag FIFO depth (power of 2, >=2)
//   STARVE_MAX   3  consecutive DM grants allowed while IF waits before IF is forced
// PORTS
//   Clk        in   1       clock; all state updates on the rising edge
//   Reset      in   1       synchronous, active-low reset
//   if_req     in   1       IF read request
//   if_addr    in   32      IF byte address
//   if_gnt     out  1       IF request accepted this cycle
//   if_rvalid  out  1       IF read data valid (1-cycle pulse)
//   if_rdata   out  32      IF read data
//   dm_req     in   1       DM request
//   dm_we      in   1       DM write (1) or read (0)
//   dm_be      in   4       DM byte enables (writes)
//   dm_addr    in   32      DM byte address
//   dm_wdata   in   32      DM write data
//   dm_gnt     out  1       DM request accepted this cycle
//   dm_rvalid  out  1       DM read data valid (1-cycle pulse)
//   dm_rdata   out  32      DM read data
//   mem_req    out  1       command to memory
//   mem_we     out  1       command is a write
//   mem_be     out  4       byte enables
//   mem_addr   out  ADDR_W  byte address
//   mem_wdata  out  32      write data
//   mem_ready  in   1       memory accepts a command this cycle
//   mem_rvalid in   1       read data returned (strictly in command order)
//   mem_rdata  in   32      returned read data
//   stall_if   out  1       if_req & ~if_gnt
//   stall_dm   out  1       dm_req & ~dm_gnt
//   err        out  1       sticky protocol error
// BEHAVIOUR
//   - Reset low: every output is 0.
//     - Tag FIFO is emptied, starve_cnt=0, err=0.
//     - mem_rvalid is ignored.
//   - Grants are combinational and issue in the same cycle as the request.
//   - A read is eligible only when mem_ready=1 and the FIFO count < MAX_OUTST.
//     - A pop in the same cycle does not free the slot.
//   - A DM write is eligible whenever mem_ready=1.
//   - Arbitration:
//     - DM wins if eligible and (starve_cnt < STARVE_MAX or IF not eligible).
//     - Otherwise IF wins if eligible.
//     - At most one grant per cycle.
//   - starve_cnt (saturating):
//     - increments when dm_gnt=1 while if_req=1;
//     - clears when if_gnt=1 or if_req=0.
//   - Command mux:
//     - mem_req = if_gnt | dm_gnt.
//     - IF: mem_we=0, mem_be=4'b1111, mem_addr = {if_addr[ADDR_W-1:2], 2'b00}.
//     - DM: dm_we, dm_be, dm_addr[ADDR_W-1:0] and dm_wdata are passed through unchanged.
//   - Tag FIFO:
//     - Push SRC_IF/SRC_DM on every granted read; writes push nothing.
//     - Pop on mem_rvalid.
//     - Push and pop may occur in the same cycle; count is unchanged.
//   - Return path is zero latency: the popped tag selects the destination.
//     - if_rvalid or dm_rvalid = mem_rvalid.
//     - if_rdata and dm_rdata both = mem_rdata.
//   - mem_rvalid with an empty FIFO: no rvalid is driven and err is set.
//     - err stays set until reset.
//   - Reset asserted mid-transfer: in-flight tags are dropped.
//     - Memory-side state is reset by the same Reset.
// STRUCTURE
//   Shared package: localparams SRC_IF=1'b0 and SRC_DM=1'b1.
//   One sub-module, arb_tag_fifo:
//     - 1-bit wide, MAX_OUTST deep, wrap-around pointers;
//     - count output used for the full test.
// TESTING
//   1 Reset=0, both ports requesting, mem_ready=1 -> all outputs 0.
//     First cycle after release -> dm_gnt=1.
//   2 STARVE_MAX=3, both reads held, mem_ready=1, memory drains every cycle
//     -> grant sequence DM,DM,DM,IF,DM,DM,DM,IF.
//   3 IF read 0x10, then DM read 0x20; memory returns 0xAAAA0001 then 0xBBBB0002
//     -> if_rvalid carries 0xAAAA0001, then dm_rvalid carries 0xBBBB0002.
//   4 Four IF reads with no return -> 5th IF: if_gnt=0, stall_if=1.
//     A DM write is still granted in that state.
//     One mem_rvalid -> if_gnt=1 on the next cycle.
//   5 mem_ready=0 -> no grants, stall_if=stall_dm=1.
//     mem_rvalid with the FIFO empty -> err=1, held until Reset=0.
//   6 if_addr=0x13 -> mem_addr=0x010, mem_be=4'b1111.
//     DM write with be=4'b0011, addr=0x22 -> mem_be=4'b0011, mem_addr=0x022.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/DM single-port memory arbiter.
// Holds the return tags that mark who owns an outstanding read. It also holds the grant selector type and the command payload.
package mem_port_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    // Owner tag stored per outstanding read
    localparam logic SRC_IF = 1'b0;
    localparam logic SRC_DM = 1'b1;

    // Which port, if any, owns the memory command this cycle
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_DM   = 2'd2
    } gnt_e;

    // Memory command payload except the address, whose width is a top-level parameter
    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order owner-tag FIFO for outstanding memory reads.
// The FIFO is 1 bit wide and DEPTH entries deep, and its pointers wrap around. DEPTH must be a power of 2 and at least 2.
// Ports:
//   Clk, Reset   clock and synchronous active-low reset, which empties the FIFO
//   i_push       store i_push_tag (ignored when full)
//   i_push_tag   owner of the read being issued
//   i_pop        drop the head entry (ignored when empty)
//   o_pop_tag    head entry, valid when o_empty=0
//   o_count      number of stored entries, 0..DEPTH
//   o_empty      no entries stored
module arb_tag_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     i_push,
    input  logic                     i_push_tag,
    input  logic                     i_pop,
    output logic                     o_pop_tag,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !o_empty;

    // Tag storage has no reset: pointers alone define which entries are live
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_tag;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_pop_tag = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port pipelined memory between instruction fetch (IF) and the data port (DM).
// DM has priority, but IF is forced through after STARVE_MAX consecutive DM grants while it waits.
// Reads are tagged in order so that returned data reaches the port that issued it.
// Ports:
//   Clk, Reset                        clock and synchronous active-low reset
//   if_req/if_addr                    IF read request
//   if_gnt/if_rvalid/if_rdata         IF grant and read return
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata  DM request
//   dm_gnt/dm_rvalid/dm_rdata         DM grant and read return
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata  command to memory
//   mem_ready/mem_rvalid/mem_rdata    memory handshake and in-order read return
//   stall_if/stall_dm                 request pending but not granted
//   err                               sticky: read data returned with nothing outstanding
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned MAX_OUTST  = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                if_req,
    input  logic [31:0]         if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [31:0]         if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [3:0]          dm_be,
    input  logic [31:0]         dm_addr,
    input  logic [31:0]         dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [31:0]         dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [3:0]          mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [31:0]         mem_rdata,
    output logic                stall_if,
    output logic                stall_dm,
    output logic                err
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    logic [STV_W-1:0]  r_starve;
    logic              r_err;

    logic              w_run;
    logic              w_rd_room;
    logic              w_if_elig;
    logic              w_dm_elig;
    gnt_e              w_sel;
    mem_cmd_t          w_cmd;
    logic [ADDR_W-1:0] w_cmd_addr;
    logic              w_push;
    logic              w_push_tag;
    logic              w_pop;
    logic              w_pop_tag;
    logic [CNT_W-1:0]  w_count;
    logic              w_empty;
    logic              w_unused;

    // Reset forces every combinational output low, so all paths are qualified by w_run
    assign w_run = Reset;

    // The current count is compared, so a same-cycle pop does not free a slot for a new read
    assign w_rd_room = (w_count < CNT_W'(MAX_OUTST));
    assign w_if_elig = w_run && if_req && mem_ready && w_rd_room;
    assign w_dm_elig = w_run && dm_req && mem_ready && (dm_we || w_rd_room);

    // Per-cycle arbitration: DM first unless IF has waited STARVE_MAX DM grants
    always_comb begin
        w_sel = GNT_NONE;
        if (w_dm_elig && ((r_starve < STV_W'(STARVE_MAX)) || !w_if_elig)) begin
            w_sel = GNT_DM;
        end else if (w_if_elig) begin
            w_sel = GNT_IF;
        end
    end

    // Command mux: IF reads are whole aligned words; DM passes through untouched
    always_comb begin
        w_cmd      = '0;
        w_cmd_addr = '0;
        case (w_sel)
            GNT_IF: begin
                w_cmd.we    = 1'b0;
                w_cmd.be    = 4'b1111;
                w_cmd_addr  = {if_addr[ADDR_W-1:2], 2'b00};
            end
            GNT_DM: begin
                w_cmd.we    = dm_we;
                w_cmd.be    = dm_be;
                w_cmd.wdata = dm_wdata;
                w_cmd_addr  = dm_addr[ADDR_W-1:0];
            end
            default: begin
                w_cmd      = '0;
                w_cmd_addr = '0;
            end
        endcase
    end

    assign if_gnt    = (w_sel == GNT_IF);
    assign dm_gnt    = (w_sel == GNT_DM);
    assign mem_req   = if_gnt || dm_gnt;
    assign mem_we    = w_cmd.we;
    assign mem_be    = w_cmd.be;
    assign mem_addr  = w_cmd_addr;
    assign mem_wdata = w_cmd.wdata;

    assign stall_if  = w_run && if_req && !if_gnt;
    assign stall_dm  = w_run && dm_req && !dm_gnt;

    // Every granted read records its owner; writes expect no return
    assign w_push     = if_gnt || (dm_gnt && !dm_we);
    assign w_push_tag = dm_gnt ? SRC_DM : SRC_IF;
    assign w_pop      = w_run && mem_rvalid && !w_empty;

    arb_tag_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .Clk        (Clk),
        .Reset      (Reset),
        .i_push     (w_push),
        .i_push_tag (w_push_tag),
        .i_pop      (w_pop),
        .o_pop_tag  (w_pop_tag),
        .o_count    (w_count),
        .o_empty    (w_empty)
    );

    // Zero-latency return: the head tag steers the returned beat
    assign if_rvalid = w_pop && (w_pop_tag == SRC_IF);
    assign dm_rvalid = w_pop && (w_pop_tag == SRC_DM);
    assign if_rdata  = w_run ? mem_rdata : '0;
    assign dm_rdata  = w_run ? mem_rdata : '0;

    // Count of consecutive DM grants taken while IF keeps asking (saturating)
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_starve <= '0;
        end else if (if_gnt || !if_req) begin
            r_starve <= '0;
        end else if (dm_gnt && (r_starve != STV_W'(STARVE_MAX))) begin
            r_starve <= r_starve + STV_W'(1);
        end
    end

    // Sticky error: memory returned data that no read was waiting for
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_err <= 1'b0;
        end else if (mem_rvalid && w_empty) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

    // Address bits above the memory window and IF byte offsets are intentionally dropped
    assign w_unused = ^{if_addr[31:ADDR_W], if_addr[1:0], dm_addr[31:ADDR_W]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        Clk;
    logic        Reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_dm;
    logic        err;

    int total = 0;
    int bad   = 0;

    // Scoreboard: {owner is DM, data} expected on the return ports, in order
    logic [32:0] exp_q[$];
    // Data the modelled memory will return for each issued read
    logic [31:0] resp_q[$];

    mem_port_arbiter #(
        .ADDR_W     (12),
        .MAX_OUTST  (4),
        .STARVE_MAX (3)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_be      (dm_be),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_gnt     (dm_gnt),
        .dm_rvalid  (dm_rvalid),
        .dm_rdata   (dm_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .stall_if   (stall_if),
        .stall_dm   (stall_dm),
        .err        (err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Return-path monitor: every rvalid pulse must match the head of the scoreboard
    always @(negedge Clk) begin
        if (Reset && (if_rvalid || dm_rvalid)) begin
            logic [32:0] e;
            logic [33:0] obs;
            logic [33:0] req;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rvalid if_rvalid=%b dm_rvalid=%b required none", if_rvalid, dm_rvalid);
            end else begin
                e   = exp_q.pop_front();
                obs = {if_rvalid, dm_rvalid, (dm_rvalid ? dm_rdata : if_rdata)};
                req = {~e[32], e[32], e[31:0]};
                if (obs !== req) begin
                    bad++;
                    $display("FAIL return_route got {if,dm,data}=%b,%b,%h required %b,%b,%h",
                             obs[33], obs[32], obs[31:0], req[33], req[32], req[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic apply_reset();
        Reset      = 1'b0;
        if_req     = 1'b0;
        if_addr    = '0;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        dm_be      = '0;
        dm_addr    = '0;
        dm_wdata   = '0;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        tick();
        tick();
        exp_q.delete();
        resp_q.delete();
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [120:0] obs;
        Reset      = 1'b0;
        if_req     = 1'b1;
        if_addr    = 32'h40;
        dm_req     = 1'b1;
        dm_we      = 1'b0;
        dm_be      = 4'hF;
        dm_addr    = 32'h80;
        dm_wdata   = 32'hCAFEF00D;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        tick();
        tick();
        settle();
        obs = {if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, mem_req, mem_we,
               mem_be, mem_addr, mem_wdata, stall_if, stall_dm, err};
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL reset_outputs got %h required 0", obs);
        end
        exp_q.delete();
        resp_q.delete();
        mem_rvalid = 1'b0;
        Reset      = 1'b1;
        settle();
        total++;
        if ({dm_gnt, if_gnt, stall_if, stall_dm, err} !== 5'b10100) begin
            bad++;
            $display("FAIL release_first_grant got {dm_gnt,if_gnt,stall_if,stall_dm,err}=%b required 10100",
                     {dm_gnt, if_gnt, stall_if, stall_dm, err});
        end
    endtask

    task automatic test_starvation();
        logic [7:0]  seq;
        logic [31:0] d;
        logic        pending;
        seq     = 8'b0111_0111;   // bit i=1: DM wins cycle i
        pending = 1'b0;
        apply_reset();
        if_req  = 1'b1;
        if_addr = 32'h100;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h200;
        for (int i = 0; i < 8; i++) begin
            if (pending) begin
                mem_rvalid = 1'b1;
                mem_rdata  = resp_q.pop_front();
            end else begin
                mem_rvalid = 1'b0;
            end
            settle();
            total++;
            if ({dm_gnt, if_gnt} !== {seq[i], ~seq[i]}) begin
                bad++;
                $display("FAIL starve_seq[%0d] got {dm,if}=%b%b required %b%b",
                         i, dm_gnt, if_gnt, seq[i], ~seq[i]);
            end
            d = 32'h5000_0000 + 32'(i);
            exp_q.push_back({seq[i], d});
            resp_q.push_back(d);
            pending = 1'b1;
            tick();
        end
        if_req     = 1'b0;
        dm_req     = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = resp_q.pop_front();
        tick();
        mem_rvalid = 1'b0;
        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL starve_returns_missing got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_return_routing();
        apply_reset();
        if_req  = 1'b1;
        if_addr = 32'h10;
        settle();
        total++;
        if ({if_gnt, dm_gnt} !== 2'b10) begin
            bad++;
            $display("FAIL route_if_grant got {if,dm}=%b%b required 10", if_gnt, dm_gnt);
        end
        exp_q.push_back({1'b0, 32'hAAAA0001});
        resp_q.push_back(32'hAAAA0001);
        tick();
        if_req     = 1'b0;
        dm_req     = 1'b1;
        dm_we      = 1'b0;
        dm_addr    = 32'h20;
        mem_rvalid = 1'b1;
        mem_rdata  = resp_q.pop_front();
        settle();
        total++;
        if ({if_gnt, dm_gnt, mem_addr} !== {2'b01, 12'h020}) begin
            bad++;
            $display("FAIL route_dm_grant got {if,dm,addr}=%b%b,%h required 01,020", if_gnt, dm_gnt, mem_addr);
        end
        exp_q.push_back({1'b1, 32'hBBBB0002});
        resp_q.push_back(32'hBBBB0002);
        tick();
        dm_req     = 1'b0;
        mem_rdata  = resp_q.pop_front();
        tick();
        mem_rvalid = 1'b0;
        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL route_returns_missing got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_outstanding_limit();
        logic [31:0] d;
        apply_reset();
        if_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if_addr = 32'h40 + 32'(i * 4);
            settle();
            total++;
            if (if_gnt !== 1'b1) begin
                bad++;
                $display("FAIL outst_if_grant[%0d] got %b required 1", i, if_gnt);
            end
            d = 32'h7000_0000 + 32'(i);
            exp_q.push_back({1'b0, d});
            resp_q.push_back(d);
            tick();
        end
        settle();
        total++;
        if ({if_gnt, stall_if} !== 2'b01) begin
            bad++;
            $display("FAIL outst_full_stall got {if_gnt,stall_if}=%b%b required 01", if_gnt, stall_if);
        end
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_be    = 4'hF;
        dm_addr  = 32'h300;
        dm_wdata = 32'h0BADF00D;
        settle();
        total++;
        if ({dm_gnt, mem_we, if_gnt} !== 3'b110) begin
            bad++;
            $display("FAIL outst_write_passes got {dm_gnt,mem_we,if_gnt}=%b required 110",
                     {dm_gnt, mem_we, if_gnt});
        end
        tick();
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = resp_q.pop_front();
        settle();
        total++;
        if (if_gnt !== 1'b0) begin
            bad++;
            $display("FAIL outst_pop_same_cycle got if_gnt=%b required 0", if_gnt);
        end
        tick();
        mem_rvalid = 1'b0;
        settle();
        total++;
        if (if_gnt !== 1'b1) begin
            bad++;
            $display("FAIL outst_after_pop got if_gnt=%b required 1", if_gnt);
        end
    endtask

    task automatic test_stall_and_err();
        apply_reset();
        mem_ready = 1'b0;
        if_req    = 1'b1;
        dm_req    = 1'b1;
        dm_we     = 1'b0;
        settle();
        total++;
        if ({if_gnt, dm_gnt, mem_req, stall_if, stall_dm} !== 5'b00011) begin
            bad++;
            $display("FAIL not_ready_stall got %b required 00011", {if_gnt, dm_gnt, mem_req, stall_if, stall_dm});
        end
        dm_we = 1'b1;
        settle();
        total++;
        if (dm_gnt !== 1'b0) begin
            bad++;
            $display("FAIL not_ready_write got dm_gnt=%b required 0", dm_gnt);
        end
        if_req     = 1'b0;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        settle();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_before_edge got %b required 0", err);
        end
        tick();
        mem_rvalid = 1'b0;
        tick();
        tick();
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky got %b required 1", err);
        end
        Reset = 1'b0;
        tick();
        settle();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_cleared got %b required 0", err);
        end
        Reset = 1'b1;
    endtask

    task automatic test_cmd_mux();
        apply_reset();
        if_req  = 1'b1;
        if_addr = 32'h13;
        settle();
        total++;
        if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'b1111, 12'h010}) begin
            bad++;
            $display("FAIL mux_if got req/we/be/addr=%b/%b/%b/%h required 1/0/1111/010",
                     mem_req, mem_we, mem_be, mem_addr);
        end
        if_req   = 1'b0;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_be    = 4'b0011;
        dm_addr  = 32'h22;
        dm_wdata = 32'h1234_5678;
        settle();
        total++;
        if ({mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 4'b0011, 12'h022, 32'h1234_5678}) begin
            bad++;
            $display("FAIL mux_dm_write got we/be/addr/wdata=%b/%b/%h/%h required 1/0011/022/12345678",
                     mem_we, mem_be, mem_addr, mem_wdata);
        end
        dm_we   = 1'b0;
        dm_be   = 4'b0101;
        dm_addr = 32'hFFFF_F7FD;
        settle();
        total++;
        if ({mem_we, mem_be, mem_addr} !== {1'b0, 4'b0101, 12'h7FD}) begin
            bad++;
            $display("FAIL mux_dm_read got we/be/addr=%b/%b/%h required 0/0101/7fd", mem_we, mem_be, mem_addr);
        end
        dm_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_starvation();
        test_return_routing();
        test_outstanding_limit();
        test_stall_and_err();
        test_cmd_mux();
        apply_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
